mux_rr_arbiter: RTL and testbench

//  Shares one W-bit output mux between N requesters using round-robin arbitration.

---
 rtl/mux_rr_arbiter_pkg.sv | 14 +
 rtl/mux_rr_arbiter_if.sv | 26 ++
 rtl/mux_rr_arbiter_pick.sv | 36 +++
 rtl/mux_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// mux_arb_pkg: shared types and helpers for the round-robin mux arbiter.
// Lock FSM states and a width helper that never returns zero.
package mux_arb_pkg;

  typedef enum logic {ARB, LOCKED} arb_state_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: requester source ports and registered sink port.
// master drives requests and out_ready; slave is the arbiter side.
interface mux_rr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready;
  logic [N-1:0]   grant;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, grant
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, grant
  );
endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// rr_priority_pick: first set request at or after ptr, wrapping.
// Rotates a doubled request vector, then finds the first set bit.
module rr_priority_pick
  import mux_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  // rotate so ptr sits at bit 0, pick lowest, map back
  always_comb begin : pick
    logic [N-1:0] rot;
    logic         found;
    int           j;
    rot   = N'({req, req} >> ptr);
    found = 1'b0;
    j     = 0;
    gnt   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        j     = i + int'(ptr);
        if (j >= N) j = j - N;
        idx      = PW'(j);
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin N:1 mux with a registered valid/ready output.
// Define MUX_ARB_LOCK_EN to hold the grant until a packet's last beat.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic            clk,
  input logic            rst,
  mux_rr_arbiter_if.slave bus
);

  localparam int PW = clog2_min1(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] pidx;
  logic [PW-1:0] g;
  logic [PW-1:0] nxt;
  logic [N-1:0]  pgnt;
  logic [N-1:0]  gnt;
  logic          can_load;
  logic          xfer;
  logic          mux_l;
  logic [W-1:0]  mux_d;
  logic          ov;
  logic          ol;
  logic [W-1:0]  od;

`ifdef MUX_ARB_LOCK_EN
  arb_state_t    state;
  logic [PW-1:0] lock_idx;
`endif

  rr_priority_pick #(.N(N), .PW(PW)) u_pick (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (pgnt),
    .idx (pidx)
  );

  // grant from the round-robin pick, or pinned while a packet is locked
  always_comb begin
`ifdef MUX_ARB_LOCK_EN
    gnt = pgnt;
    g   = pidx;
    if (state == LOCKED) begin
      gnt           = '0;
      gnt[lock_idx] = 1'b1;
      g             = lock_idx;
    end
`else
    gnt = pgnt;
    g   = pidx;
`endif
  end

  assign can_load      = !ov || bus.out_ready;
  assign bus.req_ready = gnt & {N{can_load & !rst}};
  assign bus.grant     = gnt;
  assign xfer          = |(bus.req_valid & bus.req_ready);
  assign nxt = (g == PW'(N - 1)) ? '0 : g + 1'b1;

  // AND-OR data mux steered by the one-hot grant
  always_comb begin
    mux_d = '0;
    mux_l = 1'b0;
    for (int i = 0; i < N; i++) begin
      mux_d = mux_d | ({W{gnt[i]}} & bus.req_data[i*W +: W]);
      mux_l = mux_l | (gnt[i] & bus.req_last[i]);
    end
  end

  // output register, round-robin pointer and packet lock
  always_ff @(posedge clk) begin
    if (rst) begin
      ov  <= 1'b0;
      od  <= '0;
      ol  <= 1'b0;
      ptr <= '0;
`ifdef MUX_ARB_LOCK_EN
      state    <= ARB;
      lock_idx <= '0;
`endif
    end else begin
      if (xfer) begin
        ov <= 1'b1;
        od <= mux_d;
        ol <= mux_l;
      end else if (bus.out_ready) begin
        ov <= 1'b0;
      end
`ifdef MUX_ARB_LOCK_EN
      unique case (state)
        ARB: begin
          if (xfer && !mux_l) begin
            state    <= LOCKED;
            lock_idx <= g;
          end else if (xfer) begin
            ptr <= nxt;
          end
        end
        LOCKED: begin
          if (xfer && mux_l) begin
            state <= ARB;
            ptr   <= nxt;
          end
        end
        default: state <= ARB;
      endcase
`else
      if (xfer) ptr <= nxt;
`endif
    end
  end

  assign bus.out_valid = ov;
  assign bus.out_data  = od;
  assign bus.out_last  = ol;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: scoreboard bench for the round-robin mux arbiter.
// Define MUX_ARB_LOCK_EN here too when building the locking variant.
module tb_mux_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.N(N), .W(W)) ifc ();

  mux_rr_arbiter #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int checks   = 0;
  int failures = 0;

  beat_t        sb[$];
  logic [W-1:0] obs[$];

  int m_ptr;
  bit m_lock;
  int m_lidx;
  bit m_ov;
  int n0;

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    if (m_lock) begin
      r[m_lidx] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (v[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic set_data(input int i, input logic [W-1:0] d);
    ifc.req_data[i*W +: W] = d;
  endtask

  // inputs already driven just after a negedge; checks, then next negedge
  task automatic cycle();
    logic [N-1:0] eg;
    logic [N-1:0] er;
    bit           can;
    int           gi;
    beat_t        b;
    #1;
    if (rst) begin
      checks++;
      if (ifc.req_ready !== '0) begin
        failures++;
        $display("FAIL rst_ready got=%b want=%b", ifc.req_ready, 4'b0000);
      end
      m_ptr  = 0;
      m_lock = 0;
      m_lidx = 0;
      m_ov   = 0;
      sb.delete();
      @(negedge clk);
      return;
    end
    eg  = model_grant(ifc.req_valid);
    can = !m_ov || ifc.out_ready;
    er  = eg & {N{can}};
    checks++;
    if (ifc.grant !== eg) begin
      failures++;
      $display("FAIL grant got=%b want=%b", ifc.grant, eg);
    end
    checks++;
    if (ifc.req_ready !== er) begin
      failures++;
      $display("FAIL req_ready got=%b want=%b", ifc.req_ready, er);
    end
    checks++;
    if (ifc.out_valid !== m_ov) begin
      failures++;
      $display("FAIL out_valid got=%b want=%b", ifc.out_valid, m_ov);
    end
    if (m_ov && ifc.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_empty got=beat want=none");
      end else begin
        b = sb.pop_front();
        if ({ifc.out_data, ifc.out_last} !== b) begin
          failures++;
          $display("FAIL out_beat got=%h/%b want=%h/%b",
                   ifc.out_data, ifc.out_last, b.d, b.l);
        end
        obs.push_back(ifc.out_data);
      end
    end
    if (can && |(ifc.req_valid & eg)) begin
      gi = 0;
      for (int i = 0; i < N; i++) if (eg[i]) gi = i;
      b.d = ifc.req_data[gi*W +: W];
      b.l = ifc.req_last[gi];
      sb.push_back(b);
      m_ov = 1;
      if (gi == 0) n0++;
`ifdef MUX_ARB_LOCK_EN
      if (!b.l) begin
        m_lock = 1;
        m_lidx = gi;
      end else begin
        m_lock = 0;
        m_ptr  = (gi + 1) % N;
      end
`else
      m_ptr = (gi + 1) % N;
`endif
    end else if (ifc.out_ready) begin
      m_ov = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.req_valid = 4'b1111;
    cycle();
    cycle();
    rst = 1'b0;
    ifc.req_valid = 4'b0000;
    ifc.out_ready = 1'b0;
    #1;
    checks++;
    if (ifc.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ov got=%b want=0", ifc.out_valid);
    end
    checks++;
    if (ifc.req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready got=%b want=0000", ifc.req_ready);
    end
    ifc.req_valid = 4'b1111;
    #1;
    checks++;
    if (ifc.grant !== 4'b0001) begin
      failures++;
      $display("FAIL reset_ptr got=%b want=0001", ifc.grant);
    end
    ifc.req_valid = 4'b0000;
    ifc.out_ready = 1'b1;
    cycle();
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp [5];
    exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    obs.delete();
    for (int i = 0; i < N; i++) set_data(i, W'(8'hA0 + i));
    ifc.req_last  = 4'b1111;
    ifc.req_valid = 4'b1111;
    repeat (5) cycle();
    ifc.req_valid = 4'b0000;
    repeat (2) cycle();
    checks++;
    if (obs.size() != 5) begin
      failures++;
      $display("FAIL rr_count got=%0d want=5", obs.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (obs[i] !== exp[i]) begin
          failures++;
          $display("FAIL rr_seq%0d got=%h want=%h", i, obs[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_single();
    ifc.req_valid = 4'b0100;
    #1;
    checks++;
    if (ifc.grant !== 4'b0100) begin
      failures++;
      $display("FAIL single2 got=%b want=0100", ifc.grant);
    end
    cycle();
    ifc.req_valid = 4'b0010;
    #1;
    checks++;
    if (ifc.grant !== 4'b0010) begin
      failures++;
      $display("FAIL single1 got=%b want=0010", ifc.grant);
    end
    cycle();
    ifc.req_valid = 4'b0000;
    repeat (2) cycle();
    ifc.req_valid = 4'b1111;
    #1;
    checks++;
    if (ifc.grant !== 4'b0100) begin
      failures++;
      $display("FAIL ptr_is2 got=%b want=0100", ifc.grant);
    end
    ifc.req_valid = 4'b0000;
    cycle();
  endtask

  task automatic test_backpressure();
    ifc.out_ready = 1'b0;
    set_data(3, 8'h5C);
    ifc.req_valid = 4'b1000;
    cycle();
    set_data(3, 8'h6D);
    repeat (3) begin
      #1;
      checks++;
      if (ifc.req_ready !== 4'b0000 || ifc.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold got=%b/%b want=0000/1",
                 ifc.req_ready, ifc.out_valid);
      end
      checks++;
      if (ifc.out_data !== 8'h5C) begin
        failures++;
        $display("FAIL bp_data got=%h want=5c", ifc.out_data);
      end
      cycle();
    end
    ifc.out_ready = 1'b1;
    cycle();
    ifc.req_valid = 4'b0000;
    repeat (2) cycle();
  endtask

  task automatic test_packet_lock();
    logic [W-1:0] exp [4];
`ifdef MUX_ARB_LOCK_EN
    exp = '{8'h10, 8'h11, 8'h12, 8'h20};
`else
    exp = '{8'h10, 8'h20, 8'h11, 8'h20};
`endif
    rst = 1'b1;
    ifc.req_valid = 4'b0000;
    cycle();
    rst = 1'b0;
    obs.delete();
    n0 = 0;
    ifc.out_ready = 1'b1;
    repeat (4) begin
      ifc.req_valid = {2'b00, 1'b1, (n0 < 3)};
      ifc.req_last  = {3'b111, (n0 == 2)};
      set_data(0, W'(8'h10 + n0));
      set_data(1, 8'h20);
      cycle();
    end
    ifc.req_valid = 4'b0000;
    repeat (2) cycle();
    checks++;
    if (obs.size() != 4) begin
      failures++;
      $display("FAIL pkt_count got=%0d want=4", obs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs[i] !== exp[i]) begin
          failures++;
          $display("FAIL pkt_seq%0d got=%h want=%h", i, obs[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_locked();
    ifc.out_ready = 1'b0;
    ifc.req_last  = 4'b1110;
    set_data(0, 8'h33);
    ifc.req_valid = 4'b0001;
    cycle();
    ifc.req_valid = 4'b0010;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    ifc.req_valid = 4'b0000;
    #1;
    checks++;
    if (ifc.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstlk_ov got=%b want=0", ifc.out_valid);
    end
    ifc.req_valid = 4'b1111;
    #1;
    checks++;
    if (ifc.grant !== 4'b0001) begin
      failures++;
      $display("FAIL rstlk_gnt got=%b want=0001", ifc.grant);
    end
    ifc.req_valid = 4'b0000;
    ifc.out_ready = 1'b1;
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    ifc.req_valid = '0;
    ifc.req_data  = '0;
    ifc.req_last  = '1;
    ifc.out_ready = 1'b1;
    m_ptr  = 0;
    m_lock = 0;
    m_lidx = 0;
    m_ov   = 0;
    n0     = 0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_packet_lock();
    test_reset_locked();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
